versatile_fifo_mc_ram: RTL and testbench



---
 rtl/versatile_fifo_mc_ram.sv | 172 +++++++++++++++++
 tb/tb_versatile_fifo_mc_ram.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/versatile_fifo_mc_ram.sv
`default_nettype none
// ============================================================================
// Module      : versatile_fifo_mc_ram
// Description : Single-clock multi-channel FIFO. 2**CH_BITS logical queues
//               share one dual-port RAM split into equal per-channel regions.
//               Per-channel pointers, registered full/empty/almost-full flags
//               and per-channel flush.
//               Optional sticky overflow/underflow flags are enabled with the
//               macro VERSATILE_FIFO_MC_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module versatile_fifo_mc_ram #(
    parameter int DATA_WIDTH  = 8,
    parameter int CH_BITS     = 2,
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [CH_BITS-1:0]      wr_ch,
    input  logic [DATA_WIDTH-1:0]   wr_d,
    input  logic                    rd_en,
    input  logic [CH_BITS-1:0]      rd_ch,
    output logic [DATA_WIDTH-1:0]   rd_q,
    output logic                    rd_valid,
    input  logic                    flush_en,
    input  logic [CH_BITS-1:0]      flush_ch,
    output logic [2**CH_BITS-1:0]   full,
    output logic [2**CH_BITS-1:0]   empty,
    output logic [2**CH_BITS-1:0]   afull
`ifdef VERSATILE_FIFO_MC_ERR_EN
    ,
    output logic [2**CH_BITS-1:0]   ovf,
    output logic [2**CH_BITS-1:0]   udf,
    input  logic                    err_clr
`endif
);

    localparam int c_NCH   = 2**CH_BITS;
    localparam int c_DEPTH = 2**ADDR_WIDTH;
    localparam int c_PW    = ADDR_WIDTH + 1;
    localparam int c_AW    = CH_BITS + ADDR_WIDTH;

    localparam logic [c_PW-1:0] c_ONE   = c_PW'(1);
    localparam logic [c_PW-1:0] c_MSB   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [c_PW-1:0] c_AFULL = c_PW'(AFULL_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [0:c_NCH*c_DEPTH-1];

    logic [c_PW-1:0]       r_wr_ptr [c_NCH];
    logic [c_PW-1:0]       r_rd_ptr [c_NCH];
    logic [c_NCH-1:0]      r_full;
    logic [c_NCH-1:0]      r_empty;
    logic [c_NCH-1:0]      r_afull;
    logic [DATA_WIDTH-1:0] r_rd_q;
    logic                  r_rd_valid;

    logic [c_PW-1:0]       w_wr_ptr_nxt [c_NCH];
    logic [c_PW-1:0]       w_rd_ptr_nxt [c_NCH];
    logic [c_PW-1:0]       w_occ_nxt    [c_NCH];
    logic [c_NCH-1:0]      w_wr_sel;
    logic [c_NCH-1:0]      w_rd_sel;
    logic [c_NCH-1:0]      w_fl_sel;
    logic [c_NCH-1:0]      w_full_nxt;
    logic [c_NCH-1:0]      w_empty_nxt;
    logic [c_NCH-1:0]      w_afull_nxt;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [c_AW-1:0]       w_wr_addr;
    logic [c_AW-1:0]       w_rd_addr;

    // Acceptance looks only at flags registered at the start of the cycle,
    // so there is no same-cycle write-to-read bypass.
    assign w_wr_acc  = wr_en & ~r_full[wr_ch]  & ~(flush_en & (flush_ch == wr_ch));
    assign w_rd_acc  = rd_en & ~r_empty[rd_ch] & ~(flush_en & (flush_ch == rd_ch));
    assign w_wr_addr = {wr_ch, r_wr_ptr[wr_ch][ADDR_WIDTH-1:0]};
    assign w_rd_addr = {rd_ch, r_rd_ptr[rd_ch][ADDR_WIDTH-1:0]};

    for (genvar gi = 0; gi < c_NCH; gi++) begin : g_ch
        assign w_wr_sel[gi] = w_wr_acc & (wr_ch == CH_BITS'(gi));
        assign w_rd_sel[gi] = w_rd_acc & (rd_ch == CH_BITS'(gi));
        assign w_fl_sel[gi] = flush_en & (flush_ch == CH_BITS'(gi));

        assign w_wr_ptr_nxt[gi] = w_wr_sel[gi] ? r_wr_ptr[gi] + c_ONE : r_wr_ptr[gi];
        // Flush drains the channel by catching the read pointer up to the
        // (unchanged, since a same-cycle write is dropped) write pointer.
        assign w_rd_ptr_nxt[gi] = w_fl_sel[gi] ? r_wr_ptr[gi] :
                                  w_rd_sel[gi] ? r_rd_ptr[gi] + c_ONE : r_rd_ptr[gi];

        assign w_occ_nxt[gi]   = w_wr_ptr_nxt[gi] - w_rd_ptr_nxt[gi];
        assign w_empty_nxt[gi] = (w_wr_ptr_nxt[gi] == w_rd_ptr_nxt[gi]);
        assign w_full_nxt[gi]  = ((w_wr_ptr_nxt[gi] ^ w_rd_ptr_nxt[gi]) == c_MSB);
        assign w_afull_nxt[gi] = (w_occ_nxt[gi] >= c_AFULL);
    end

    // Shared RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[w_wr_addr] <= wr_d;
        end
    end

    // Per-channel pointers and flags advance together on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NCH; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
            end
            r_full  <= '0;
            r_empty <= '1;
            r_afull <= '0;
        end else begin
            for (int i = 0; i < c_NCH; i++) begin
                r_wr_ptr[i] <= w_wr_ptr_nxt[i];
                r_rd_ptr[i] <= w_rd_ptr_nxt[i];
            end
            r_full  <= w_full_nxt;
            r_empty <= w_empty_nxt;
            r_afull <= w_afull_nxt;
        end
    end

    // Registered read port: one cycle latency, data holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_q     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_q <= r_mem[w_rd_addr];
            end
        end
    end

    assign rd_q     = r_rd_q;
    assign rd_valid = r_rd_valid;
    assign full     = r_full;
    assign empty    = r_empty;
    assign afull    = r_afull;

`ifdef VERSATILE_FIFO_MC_ERR_EN
    logic [c_NCH-1:0] r_ovf;
    logic [c_NCH-1:0] r_udf;
    logic [c_NCH-1:0] w_ovf_set;
    logic [c_NCH-1:0] w_udf_set;

    // Drops caused by a flush on the same channel are not errors.
    for (genvar gi = 0; gi < c_NCH; gi++) begin : g_err
        assign w_ovf_set[gi] = wr_en & (wr_ch == CH_BITS'(gi)) & r_full[gi]  & ~w_fl_sel[gi];
        assign w_udf_set[gi] = rd_en & (rd_ch == CH_BITS'(gi)) & r_empty[gi] & ~w_fl_sel[gi];
    end

    // Sticky error flags; a new event wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= '0;
            r_udf <= '0;
        end else begin
            r_ovf <= (err_clr ? '0 : r_ovf) | w_ovf_set;
            r_udf <= (err_clr ? '0 : r_udf) | w_udf_set;
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_versatile_fifo_mc_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_versatile_fifo_mc_ram
// Description : Self-checking bench for versatile_fifo_mc_ram (default
//               parameters). Queue-based reference model plus directed
//               vectors with literal expectations. Covers the optional
//               VERSATILE_FIFO_MC_ERR_EN ports when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_versatile_fifo_mc_ram;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_d;
    logic       rd_en;
    logic [1:0] rd_ch;
    logic [7:0] rd_q;
    logic       rd_valid;
    logic       flush_en;
    logic [1:0] flush_ch;
    logic [3:0] full;
    logic [3:0] empty;
    logic [3:0] afull;
`ifdef VERSATILE_FIFO_MC_ERR_EN
    logic [3:0] ovf;
    logic [3:0] udf;
    logic       err_clr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    versatile_fifo_mc_ram dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_d     (wr_d),
        .rd_en    (rd_en),
        .rd_ch    (rd_ch),
        .rd_q     (rd_q),
        .rd_valid (rd_valid),
        .flush_en (flush_en),
        .flush_ch (flush_ch),
        .full     (full),
        .empty    (empty),
        .afull    (afull)
`ifdef VERSATILE_FIFO_MC_ERR_EN
        ,
        .ovf      (ovf),
        .udf      (udf),
        .err_clr  (err_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel, state after the latest edge.
    logic [7:0] mq [4][$];
    logic [7:0] m_q     = 8'h00;
    logic       m_valid = 1'b0;
    logic [3:0] m_ovf   = 4'h0;
    logic [3:0] m_udf   = 4'h0;

    // Compare on the falling edge, then advance the model with the inputs
    // that the next rising edge will sample.
    always @(negedge clk) begin : p_model
        logic [3:0] ef, ff, af, os, us;
        logic       wacc, racc, wfl, rfl;
        for (int c = 0; c < 4; c++) begin
            ef[c] = (mq[c].size() == 0);
            ff[c] = (mq[c].size() == 16);
            af[c] = (mq[c].size() >= 12);
        end
        check("empty", 32'(empty), 32'(ef));
        check("full", 32'(full), 32'(ff));
        check("afull", 32'(afull), 32'(af));
        check("rd_valid", 32'(rd_valid), 32'(m_valid));
        check("rd_q", 32'(rd_q), 32'(m_q));
`ifdef VERSATILE_FIFO_MC_ERR_EN
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("udf", 32'(udf), 32'(m_udf));
`endif
        if (rst) begin
            for (int c = 0; c < 4; c++) mq[c].delete();
            m_q = 8'h00; m_valid = 1'b0; m_ovf = 4'h0; m_udf = 4'h0;
        end else begin
            wfl  = flush_en && (flush_ch == wr_ch);
            rfl  = flush_en && (flush_ch == rd_ch);
            wacc = wr_en && (mq[wr_ch].size() < 16) && !wfl;
            racc = rd_en && (mq[rd_ch].size() > 0) && !rfl;
            os = 4'h0; us = 4'h0;
            if (wr_en && mq[wr_ch].size() == 16 && !wfl) os[wr_ch] = 1'b1;
            if (rd_en && mq[rd_ch].size() == 0 && !rfl) us[rd_ch] = 1'b1;
`ifdef VERSATILE_FIFO_MC_ERR_EN
            m_ovf = (err_clr ? 4'h0 : m_ovf) | os;
            m_udf = (err_clr ? 4'h0 : m_udf) | us;
`endif
            m_valid = racc;
            if (racc) m_q = mq[rd_ch].pop_front();
            if (wacc) mq[wr_ch].push_back(wr_d);
            if (flush_en) mq[flush_ch].delete();
        end
    end

    // Drive one cycle of requests, return just after the sampling edge.
    task automatic cyc(input logic we, input logic [1:0] wc, input logic [7:0] wd,
                       input logic re, input logic [1:0] rc);
        wr_en = we; wr_ch = wc; wr_d = wd; rd_en = re; rd_ch = rc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    endtask

    logic [7:0] exp3 [3];

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_d = '0;
        rd_en = 1'b0; rd_ch = '0; flush_en = 1'b0; flush_ch = '0;
`ifdef VERSATILE_FIFO_MC_ERR_EN
        err_clr = 1'b0;
`endif
        exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
        idle(); idle();
        check("rst_empty", 32'(empty), 32'hF);
        check("rst_full", 32'(full), 32'h0);
        check("rst_afull", 32'(afull), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_rd_q", 32'(rd_q), 32'h0);
        rst = 1'b0;

        // Basic in-order traffic on channel 1.
        cyc(1'b1, 2'd1, 8'h11, 1'b0, 2'd0);
        cyc(1'b1, 2'd1, 8'h22, 1'b0, 2'd0);
        cyc(1'b1, 2'd1, 8'h33, 1'b0, 2'd0);
        check("ch1_not_empty", 32'(empty), 32'hD);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
            check("ch1_rd_q", 32'(rd_q), 32'(exp3[k]));
            check("ch1_rd_valid", 32'(rd_valid), 32'h1);
        end
        check("ch1_drained", 32'(empty), 32'hF);
        idle();
        check("idle_rd_valid", 32'(rd_valid), 32'h0);
        check("idle_rd_q_hold", 32'(rd_q), 32'h33);

        // Fill channel 2, overflow attempt, drain in order.
        for (int n = 1; n <= 16; n++) begin
            cyc(1'b1, 2'd2, 8'(n), 1'b0, 2'd0);
            if (n == 11) check("ch2_afull_11", 32'(afull[2]), 32'h0);
            if (n == 12) check("ch2_afull_12", 32'(afull[2]), 32'h1);
            if (n == 15) check("ch2_full_15", 32'(full[2]), 32'h0);
            if (n == 16) check("ch2_full_16", 32'(full[2]), 32'h1);
        end
        cyc(1'b1, 2'd2, 8'h99, 1'b0, 2'd0);
        check("ch2_full_held", 32'(full), 32'h4);
        for (int n = 1; n <= 16; n++) begin
            cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
            check("ch2_rd_q", 32'(rd_q), 32'(n));
        end
        check("ch2_empty", 32'(empty[2]), 32'h1);
        cyc(1'b1, 2'd2, 8'h5A, 1'b0, 2'd0);
        cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
        check("ch2_wrap_rd_q", 32'(rd_q), 32'h5A);

        // Interleaved channels 0 and 3.
        for (int n = 0; n < 4; n++) begin
            cyc(1'b1, 2'd0, 8'(8'hA0 + n), 1'b0, 2'd0);
            cyc(1'b1, 2'd3, 8'(8'hB0 + n), 1'b0, 2'd0);
        end
        for (int n = 0; n < 4; n++) begin
            cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
            check("ch0_il_rd_q", 32'(rd_q), 32'(8'hA0 + n));
            cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
            check("ch3_il_rd_q", 32'(rd_q), 32'(8'hB0 + n));
        end

        // Full channel with same-cycle write+read, then steady occupancy.
        for (int n = 0; n < 16; n++) cyc(1'b1, 2'd0, 8'(8'h40 + n), 1'b0, 2'd0);
        check("ch0_full", 32'(full[0]), 32'h1);
        cyc(1'b1, 2'd0, 8'hEE, 1'b1, 2'd0);
        check("ch0_full_cleared", 32'(full[0]), 32'h0);
        check("ch0_first_rd_q", 32'(rd_q), 32'h40);
        for (int n = 1; n <= 10; n++) begin
            cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
            check("ch0_rd_q", 32'(rd_q), 32'(8'h40 + n));
        end
        cyc(1'b1, 2'd0, 8'h77, 1'b1, 2'd0);
        check("ch0_wr_rd_q", 32'(rd_q), 32'h4B);
        for (int n = 0; n < 5; n++) begin
            cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
            check("ch0_tail_rd_q", 32'(rd_q), (n == 4) ? 32'h77 : 32'(8'h4C + n));
        end
        check("ch0_empty", 32'(empty[0]), 32'h1);

        // Flush channel 1 with a same-cycle write.
        for (int n = 0; n < 4; n++) cyc(1'b1, 2'd1, 8'(8'h61 + n), 1'b0, 2'd0);
        flush_en = 1'b1; flush_ch = 2'd1;
        cyc(1'b1, 2'd1, 8'h65, 1'b0, 2'd0);
        flush_en = 1'b0;
        check("flush_empty", 32'(empty[1]), 32'h1);
        cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
        check("flush_rd_valid", 32'(rd_valid), 32'h0);

`ifdef VERSATILE_FIFO_MC_ERR_EN
        err_clr = 1'b1;
        idle();
        err_clr = 1'b0;
        check("err_clr0_ovf", 32'(ovf), 32'h0);
        check("err_clr0_udf", 32'(udf), 32'h0);
        cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
        check("udf_ch2", 32'(udf), 32'h4);
        for (int n = 0; n < 16; n++) cyc(1'b1, 2'd0, 8'(n), 1'b0, 2'd0);
        cyc(1'b1, 2'd0, 8'hFF, 1'b0, 2'd0);
        check("ovf_ch0", 32'(ovf), 32'h1);
        err_clr = 1'b1;
        idle();
        err_clr = 1'b0;
        check("err_clr_ovf", 32'(ovf), 32'h0);
        check("err_clr_udf", 32'(udf), 32'h0);
`endif

        // Reset in the middle of a burst.
        for (int n = 0; n < 3; n++) cyc(1'b1, 2'd3, 8'(8'h30 + n), 1'b0, 2'd0);
        cyc(1'b1, 2'd3, 8'h33, 1'b1, 2'd3);
        rst = 1'b1;
        cyc(1'b1, 2'd3, 8'h34, 1'b1, 2'd3);
        check("mid_rst_empty", 32'(empty), 32'hF);
        check("mid_rst_full", 32'(full), 32'h0);
        check("mid_rst_afull", 32'(afull), 32'h0);
        check("mid_rst_rd_valid", 32'(rd_valid), 32'h0);
        check("mid_rst_rd_q", 32'(rd_q), 32'h0);
        rst = 1'b0;
        cyc(1'b1, 2'd3, 8'h3C, 1'b0, 2'd0);
        cyc(1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
        check("post_rst_rd_q", 32'(rd_q), 32'h3C);

        idle();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
